// File: rtl/program_memory_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among per-core fetchers.
// One read is outstanding at a time; each result is returned through a per-consumer valid/ready pair.
module program_memory_arbiter #(
  parameter int NUM_CONSUMERS = 2,
  parameter int ADDR_BITS     = 8,
  parameter int INSTR_BITS    = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*INSTR_BITS-1:0] consumer_read_data,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [INSTR_BITS-1:0]               mem_read_data,
  output logic                                busy
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, REQUEST, RESPOND} state_t;

  state_t              state;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] grant;
  logic [IDX_BITS-1:0] next_ptr;

  logic                 found;
  logic [IDX_BITS-1:0]  winner;
  logic [ADDR_BITS-1:0] winner_address;
  int                   cand;

  // Scan starts at rr_ptr and wraps, so the consumer after the last grant has top priority.
  always_comb begin
    found          = 1'b0;
    winner         = rr_ptr;
    winner_address = '0;
    cand           = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_CONSUMERS;
      if (!found && consumer_read_valid[cand]) begin
        found          = 1'b1;
        winner         = cand[IDX_BITS-1:0];
        winner_address = consumer_read_address[cand*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  assign next_ptr = (grant == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant               <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      busy                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant            <= winner;
            mem_read_address <= winner_address;
            mem_read_valid   <= 1'b1;
            busy             <= 1'b1;
            state            <= REQUEST;
          end
        end
        REQUEST: begin
          if (mem_read_ready) begin
            consumer_read_data[int'(grant)*INSTR_BITS +: INSTR_BITS] <= mem_read_data;
            mem_read_valid             <= 1'b0;
            consumer_read_ready[grant] <= 1'b1;
            state                      <= RESPOND;
          end
        end
        RESPOND: begin
          // The grant is released only once the consumer has seen ready and dropped valid.
          if (!consumer_read_valid[grant]) begin
            consumer_read_ready[grant] <= 1'b0;
            rr_ptr                     <= next_ptr;
            busy                       <= 1'b0;
            state                      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed self-checking bench for program_memory_arbiter with two consumers.
module tb_program_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  consumer_read_valid;
  logic [15:0] consumer_read_address;
  logic [1:0]  consumer_read_ready;
  logic [31:0] consumer_read_data;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic        busy;

  int pass_count  = 0;
  int check_count = 0;

  program_memory_arbiter #(.NUM_CONSUMERS(2), .ADDR_BITS(8), .INSTR_BITS(16)) dut (
    .clk(clk),
    .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // At most one ready bit may ever be high, checked every cycle away from the active edge.
  always @(negedge clk) begin
    check_count++;
    assert ((consumer_read_ready & (consumer_read_ready - 2'd1)) === 2'b00) pass_count++;
    else $error("[TB] FAIL ready_onehot: observed %b expected at most one bit", consumer_read_ready);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(consumer_read_ready), 32'd0);
    checkOutput({tag, "_mvalid"}, 32'(mem_read_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Serves one transaction: waits for issue, stalls, responds, then the consumer drops valid.
  task automatic applyStimulus(input int idx, input logic [7:0] exp_addr, input logic [15:0] rdata,
                               input int stall, input bit reassert);
    int cnt = 0;
    while (mem_read_valid !== 1'b1 && cnt < 20) begin
      step(1);
      cnt++;
    end
    checkOutput("issue_valid", 32'(mem_read_valid), 32'd1);
    checkOutput("issue_addr", 32'(mem_read_address), 32'(exp_addr));
    for (int s = 0; s < stall; s++) begin
      step(1);
      if (mem_read_valid !== 1'b1 || mem_read_address !== exp_addr || busy !== 1'b1 ||
          consumer_read_ready !== 2'b00) begin
        checkOutput("stall_stable", {8'(mem_read_valid), mem_read_address, 8'(busy), 6'd0, consumer_read_ready},
                    {8'd1, exp_addr, 8'd1, 8'd0});
      end
    end
    mem_read_ready = 1'b1;
    mem_read_data  = rdata;
    step(1);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    checkOutput("resp_ready", 32'(consumer_read_ready), 32'(2'b01 << idx));
    checkOutput("resp_data", 32'(consumer_read_data[idx*16 +: 16]), 32'(rdata));
    checkOutput("resp_mvalid", 32'(mem_read_valid), 32'd0);
    consumer_read_valid[idx] = 1'b0;
    step(1);
    checkOutput("release_ready", 32'(consumer_read_ready), 32'd0);
    if (reassert) consumer_read_valid[idx] = 1'b1;
  endtask

  initial begin
    reset                 = 1'b0;
    consumer_read_valid   = 2'b00;
    consumer_read_address = 16'h0000;
    mem_read_ready        = 1'b0;
    mem_read_data         = 16'h0000;

    // Reset state
    step(2);
    checkIdleOutputs("reset");
    checkOutput("reset_data", consumer_read_data, 32'd0);
    checkOutput("reset_maddr", 32'(mem_read_address), 32'd0);
    reset = 1'b1;

    // Single read from consumer 1, memory answers two cycles after mem_read_valid
    consumer_read_address = {8'h2A, 8'h00};
    consumer_read_valid   = 2'b10;
    step(1);
    checkOutput("t1_mvalid", 32'(mem_read_valid), 32'd1);
    checkOutput("t1_addr", 32'(mem_read_address), 32'h2A);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    step(1);
    checkOutput("t1_wait_ready", 32'(consumer_read_ready), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1234;
    step(1);
    mem_read_ready = 1'b0;
    checkOutput("t1_ready", 32'(consumer_read_ready), 32'(2'b10));
    checkOutput("t1_data", consumer_read_data, 32'h1234_0000);
    step(2);
    checkOutput("t1_ready_held", 32'(consumer_read_ready), 32'(2'b10));
    consumer_read_valid = 2'b00;
    step(1);
    checkIdleOutputs("t1_done");

    // rr_ptr wrapped to 0, so consumer 0 must win a simultaneous request
    consumer_read_address = {8'h09, 8'h05};
    consumer_read_valid   = 2'b11;
    step(1);
    checkOutput("t1_rrptr_addr", 32'(mem_read_address), 32'h05);

    // Simultaneous requests straight out of reset
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    checkOutput("t2_reset_data", consumer_read_data, 32'd0);
    applyStimulus(0, 8'h05, 16'hAAAA, 0, 1'b0);
    applyStimulus(1, 8'h09, 16'hBBBB, 0, 1'b0);
    checkOutput("t2_data_both", consumer_read_data, 32'hBBBB_AAAA);

    // Continuous requests alternate 0,1,0,1,0,1
    consumer_read_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i % 2, (i % 2 == 0) ? 8'h05 : 8'h09, 16'(16'h1000 + i), 0, i < 4);
    end
    checkOutput("t3_data", consumer_read_data, 32'h1005_1004);
    step(1);
    checkIdleOutputs("t3_idle");

    // Memory stall of 20 cycles
    consumer_read_address = {8'h09, 8'h77};
    consumer_read_valid   = 2'b01;
    applyStimulus(0, 8'h77, 16'hCAFE, 20, 1'b0);
    checkOutput("t4_other_slice", 32'(consumer_read_data[31:16]), 32'h1005);

    // Reset during REQUEST, then a stale response
    consumer_read_address = {8'h33, 8'h00};
    consumer_read_valid   = 2'b10;
    step(1);
    checkOutput("t5_in_request", 32'(mem_read_valid), 32'd1);
    reset               = 1'b0;
    consumer_read_valid = 2'b00;
    step(1);
    reset = 1'b1;
    checkIdleOutputs("t5_reset");
    checkOutput("t5_reset_maddr", 32'(mem_read_address), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    step(1);
    mem_read_ready = 1'b0;
    checkIdleOutputs("t5_stale");
    checkOutput("t5_stale_data", consumer_read_data, 32'd0);
    step(1);
    checkOutput("t5_stale_ready2", 32'(consumer_read_ready), 32'd0);

    // Consumer 0 withdraws valid before memory responds
    consumer_read_address = {8'h00, 8'h10};
    consumer_read_valid   = 2'b01;
    step(1);
    checkOutput("t6_addr", 32'(mem_read_address), 32'h10);
    consumer_read_valid = 2'b00;
    step(1);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    step(1);
    mem_read_ready = 1'b0;
    checkOutput("t6_ready", 32'(consumer_read_ready), 32'(2'b01));
    checkOutput("t6_data", consumer_read_data, 32'h0000_BEEF);
    step(1);
    checkIdleOutputs("t6_done");
    checkOutput("t6_data_kept", consumer_read_data, 32'h0000_BEEF);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
